// File: rtl/car_park_control.sv
`default_nettype none
// ============================================================================
// Module   : car_park_control
// Purpose  : Single-bay car-park access controller. Detects a car at the
//            entrance, checks a 5-bit keypad passcode, opens the gate on a
//            match, tracks the car through parking and exit, and drives the
//            red/green indicator lamps and the gate lock.
// Ports    : clk             - system clock, all state on rising edge
//            rst             - synchronous active-high reset
//            park_sensor     - 1 = car present in the bay
//            entrance_sensor - 1 = car waiting at the entrance gate
//            exit_sensor     - 1 = exit request (a 1-cycle pulse suffices)
//            pass[4:0]       - keypad code, 5'b00000 = no entry
//            red_led         - stop / occupied / error indicator
//            green_led       - proceed indicator
//            lock            - 1 = gate locked, 0 = gate open
// Revision : 1.0 - initial release
// ============================================================================
module car_park_control #(
  parameter logic [4:0]  PASSWORD  = 5'b10101,
  parameter int unsigned MAX_TRIES = 3,    // 1..7
  parameter int unsigned TIMEOUT   = 255   // 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       park_sensor,
  input  logic       entrance_sensor,
  input  logic       exit_sensor,
  input  logic [4:0] pass,
  output logic       red_led,
  output logic       green_led,
  output logic       lock
);

  localparam logic [3:0] c_max_tries = 4'(MAX_TRIES);
  localparam logic [7:0] c_timeout   = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_PASS = 3'd1,
    S_GRANTED   = 3'd2,
    S_PARKED    = 3'd3,
    S_EXITING   = 3'd4,
    S_ALARM     = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] tries_q, tries_d;
  logic [7:0] tmo_q,   tmo_d;
  logic [4:0] last_q,  last_d;

  // A wrong attempt is a non-empty, incorrect code that differs from the
  // code seen on the previous cycle, so a held key counts only once.
  logic       w_new_wrong;
  logic [3:0] w_tries_plus1;

  assign w_new_wrong   = (pass != 5'd0) && (pass != PASSWORD) && (pass != last_q);
  assign w_tries_plus1 = {1'b0, tries_q} + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tries_q <= 3'd0;
      tmo_q   <= 8'd0;
      last_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      tmo_q   <= tmo_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    tmo_d   = tmo_q;
    last_d  = last_q;

    case (state_q)
      S_IDLE: begin
        if (entrance_sensor) begin
          state_d = S_WAIT_PASS;
          tries_d = 3'd0;
          tmo_d   = 8'd0;
          last_d  = 5'd0;
        end
      end

      S_WAIT_PASS: begin
        last_d = pass;
        if (!entrance_sensor) begin
          state_d = S_IDLE;
        end else if (pass == PASSWORD) begin
          state_d = S_GRANTED;
        end else if (tmo_q == c_timeout) begin
          state_d = S_IDLE;
        end else if (w_new_wrong) begin
          // Counting a fresh wrong code restarts the abandon timer.
          tmo_d = 8'd0;
          if (tries_q != 3'd7) begin
            tries_d = tries_q + 3'd1;
          end
          if (w_tries_plus1 == c_max_tries) begin
            state_d = S_ALARM;
          end
        end else begin
          if (tmo_q != 8'hFF) begin
            tmo_d = tmo_q + 8'd1;
          end
        end
      end

      S_GRANTED: begin
        // A car reaching the bay wins over the entrance sensor dropping.
        if (park_sensor) begin
          state_d = S_PARKED;
        end else if (!entrance_sensor) begin
          state_d = S_IDLE;
        end
      end

      S_PARKED: begin
        if (exit_sensor) begin
          state_d = S_EXITING;
        end
      end

      S_EXITING: begin
        if (!park_sensor) begin
          state_d = S_IDLE;
        end
      end

      S_ALARM: begin
        if (!entrance_sensor) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore decode: outputs depend on the state register only.
  always_comb begin
    red_led   = 1'b0;
    green_led = 1'b0;
    lock      = 1'b1;
    case (state_q)
      S_WAIT_PASS: red_led = 1'b1;
      S_GRANTED: begin
        green_led = 1'b1;
        lock      = 1'b0;
      end
      S_PARKED: red_led = 1'b1;
      S_EXITING: begin
        green_led = 1'b1;
        lock      = 1'b0;
      end
      S_ALARM: red_led = 1'b1;
      default: begin
        red_led   = 1'b0;
        green_led = 1'b0;
        lock      = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_car_park_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_car_park_control
// Purpose  : Directed self-checking bench for car_park_control. Inputs are
//            driven and outputs sampled on the falling clock edge; each
//            check compares {red_led, green_led, lock} against a
//            hand-computed value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_car_park_control;

  logic       clk;
  logic       rst;
  logic       park_sensor;
  logic       entrance_sensor;
  logic       exit_sensor;
  logic [4:0] pass;
  logic       red_led;
  logic       green_led;
  logic       lock;

  int errors;
  int checks;

  // {red, green, lock} for each state class
  localparam logic [2:0] c_idle = 3'b001;
  localparam logic [2:0] c_red  = 3'b101;  // WAIT_PASS / PARKED / ALARM
  localparam logic [2:0] c_go   = 3'b010;  // GRANTED / EXITING

  car_park_control #(
    .PASSWORD  (5'b10101),
    .MAX_TRIES (3),
    .TIMEOUT   (255)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .park_sensor     (park_sensor),
    .entrance_sensor (entrance_sensor),
    .exit_sensor     (exit_sensor),
    .pass            (pass),
    .red_led         (red_led),
    .green_led       (green_led),
    .lock            (lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got rgl=%b expected rgl=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [2:0] leds();
    return {red_led, green_led, lock};
  endfunction

  initial begin
    errors          = 0;
    checks          = 0;
    rst             = 1'b1;
    park_sensor     = 1'b0;
    entrance_sensor = 1'b0;
    exit_sensor     = 1'b0;
    pass            = 5'd0;

    // Reset
    cyc(2);
    check("reset", leds(), c_idle);
    rst = 1'b0;
    cyc(1);
    check("idle_hold", leds(), c_idle);

    // Normal cycle
    entrance_sensor = 1'b1;
    cyc(1);
    check("enter_wait", leds(), c_red);
    pass = 5'b00011;
    cyc(1);
    check("wrong_code", leds(), c_red);
    pass = 5'b10101;
    cyc(1);
    check("granted", leds(), c_go);
    pass = 5'd0;
    park_sensor     = 1'b1;
    entrance_sensor = 1'b0;
    cyc(1);
    check("parked", leds(), c_red);
    entrance_sensor = 1'b1;
    pass = 5'b10101;
    cyc(1);
    check("parked_ignores", leds(), c_red);
    entrance_sensor = 1'b0;
    pass = 5'd0;
    exit_sensor = 1'b1;
    cyc(1);
    exit_sensor = 1'b0;
    check("exiting", leds(), c_go);
    cyc(1);
    check("exiting_hold", leds(), c_go);
    park_sensor = 1'b0;
    cyc(1);
    check("exit_idle", leds(), c_idle);

    // Lockout after three different wrong codes
    entrance_sensor = 1'b1;
    cyc(1);
    check("lk_wait", leds(), c_red);
    pass = 5'b00001;
    cyc(2);
    pass = 5'b00010;
    cyc(2);
    check("lk_two_wrong", leds(), c_red);
    pass = 5'b00011;
    cyc(1);
    check("lk_alarm", leds(), c_red);
    pass = 5'b10101;
    cyc(2);
    check("alarm_ignores_pass", leds(), c_red);
    entrance_sensor = 1'b0;
    pass = 5'd0;
    cyc(1);
    check("alarm_leave", leds(), c_idle);

    // Held wrong code counts once
    entrance_sensor = 1'b1;
    cyc(1);
    pass = 5'b00111;
    cyc(10);
    check("held_wrong", leds(), c_red);
    pass = 5'b10101;
    cyc(1);
    check("held_then_ok", leds(), c_go);

    // Abort from GRANTED
    entrance_sensor = 1'b0;
    pass = 5'd0;
    cyc(1);
    check("abort_idle", leds(), c_idle);

    // Timeout boundary: entry at edge 0, abandon at edge 256
    entrance_sensor = 1'b1;
    cyc(256);
    check("tmo_before", leds(), c_red);
    cyc(1);
    check("tmo_idle", leds(), c_idle);
    cyc(1);
    check("tmo_reenter", leds(), c_red);

    // Reset while parked
    pass = 5'b10101;
    cyc(1);
    check("rp_granted", leds(), c_go);
    pass = 5'd0;
    park_sensor = 1'b1;
    cyc(1);
    check("rp_parked", leds(), c_red);
    rst = 1'b1;
    cyc(1);
    check("rst_parked", leds(), c_idle);
    rst = 1'b0;
    park_sensor = 1'b0;
    entrance_sensor = 1'b0;
    cyc(1);

    // Entrance and correct code together take two transitions
    entrance_sensor = 1'b1;
    pass = 5'b10101;
    cyc(1);
    check("same_cycle_wait", leds(), c_red);
    cyc(1);
    check("same_cycle_grant", leds(), c_go);
    cyc(1);
    check("granted_hold", leds(), c_go);
    rst = 1'b1;
    cyc(1);
    check("rst_granted", leds(), c_idle);
    rst = 1'b0;
    entrance_sensor = 1'b0;
    pass = 5'd0;
    cyc(1);
    check("final_idle", leds(), c_idle);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
